// File: rtl/aes128_arbiter.sv
// ---------------------------------------------------------------------------
// aes128_arbiter
// Round-robin scheduler sharing one AES-128 encrypt core among N_REQ
// requesters. A job (plaintext + key) is taken over a valid/ready handshake,
// the core is driven with a level-sensitive start and watched for a finish
// level, and the ciphertext (or a watchdog error) is returned to the granted
// requester over a valid/ready response channel.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : per-requester job request
//   req_ready    : one-hot job accept (IDLE only)
//   req_data/key : N_REQ packed 128-bit slices, slice i = requester i
//   rsp_valid    : one-hot response valid for the owning requester
//   rsp_ready    : per-requester response accept
//   rsp_data/err : shared ciphertext, err = watchdog timeout
//   aes_start    : registered core start level
//   aes_in/key   : registered core operands
//   aes_finish   : core done level
//   aes_out      : core result
//   busy         : high whenever the FSM is not IDLE
//   grant_id     : index of the current or last granted requester
// ---------------------------------------------------------------------------
module aes128_arbiter #(
   parameter int N_REQ      = 4,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ*128-1:0] req_data,
   input  logic [N_REQ*128-1:0] req_key,
   output logic [N_REQ-1:0]     rsp_valid,
   input  logic [N_REQ-1:0]     rsp_ready,
   output logic [127:0]         rsp_data,
   output logic                 rsp_err,
   output logic                 aes_start,
   output logic [127:0]         aes_in,
   output logic [127:0]         aes_key,
   input  logic                 aes_finish,
   input  logic [127:0]         aes_out,
   output logic                 busy,
   output logic [2:0]           grant_id
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int RUN_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_RUN, ST_RESP} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [GAP_W-1:0]   r_gap;
   logic [RUN_W-1:0]   r_run;
   logic [2:0]         r_grant_id;
   logic [2:0]         r_last_grant;
   logic               r_aes_start;
   logic [127:0]       r_aes_in;
   logic [127:0]       r_aes_key;
   logic [127:0]       r_rsp_data;
   logic               r_rsp_err;
   logic [N_REQ-1:0]   r_rsp_valid;

   logic               w_found;
   logic [2:0]         w_win_idx;
   logic [N_REQ-1:0]   w_win_oh;
   logic [127:0]       w_sel_data;
   logic [127:0]       w_sel_key;
   logic [N_REQ-1:0]   w_grant_oh;
   logic               w_rsp_hs;
   logic               w_fin_acc;
   logic               w_tmo;

   // Round-robin search: first the indices above the last grant, then wrap
   // around to the indices at or below it.
   always_comb begin
      w_found   = 1'b0;
      w_win_idx = '0;
      w_win_oh  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && req_valid[k] && (k > int'(r_last_grant))) begin
            w_found     = 1'b1;
            w_win_idx   = 3'(k);
            w_win_oh[k] = 1'b1;
         end
      end
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && req_valid[k] && (k <= int'(r_last_grant))) begin
            w_found     = 1'b1;
            w_win_idx   = 3'(k);
            w_win_oh[k] = 1'b1;
         end
      end
   end

   // Operand mux driven by the one-hot winner (constant part-selects only).
   always_comb begin
      w_sel_data = '0;
      w_sel_key  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_win_oh[k]) begin
            w_sel_data = req_data[k*128 +: 128];
            w_sel_key  = req_key[k*128 +: 128];
         end
      end
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant_oh
      assign w_grant_oh[gi] = (r_grant_id == 3'(gi));
   end

   // Only the owner's rsp_ready matters; other bits are masked off.
   assign w_rsp_hs  = |(rsp_ready & w_grant_oh);
   // A finish on the first RUN cycle is stale (start was low the cycle before).
   assign w_fin_acc = aes_finish && (r_run != '0);
   // Last allowed start-high cycle; the counter would reach TIMEOUT next.
   assign w_tmo     = (r_run == RUN_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_found)            w_state_next = ST_GAP;
         ST_GAP:  if (r_gap == '0)        w_state_next = ST_RUN;
         ST_RUN:  if (w_fin_acc || w_tmo) w_state_next = ST_RESP;
         ST_RESP: if (w_rsp_hs)           w_state_next = ST_IDLE;
         default:                         w_state_next = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready = (r_state == ST_IDLE) ? w_win_oh : '0;
      busy      = (r_state != ST_IDLE);
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gap        <= '0;
         r_run        <= '0;
         r_grant_id   <= '0;
         r_last_grant <= 3'(N_REQ - 1);
         r_aes_start  <= 1'b0;
         r_aes_in     <= '0;
         r_aes_key    <= '0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_rsp_valid  <= '0;
      end else begin
         // Start is a pure function of the next state so it is high exactly
         // for the RUN cycles.
         r_aes_start <= (w_state_next == ST_RUN);
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_aes_in     <= w_sel_data;
                  r_aes_key    <= w_sel_key;
                  r_grant_id   <= w_win_idx;
                  r_last_grant <= w_win_idx;
                  r_gap        <= GAP_W'(GAP_CYCLES - 1);
               end
            end
            ST_GAP: begin
               r_run <= '0;
               if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);
            end
            ST_RUN: begin
               r_run <= r_run + RUN_W'(1);
               if (w_fin_acc) begin
                  r_rsp_data  <= aes_out;
                  r_rsp_err   <= 1'b0;
                  r_rsp_valid <= w_grant_oh;
               end else if (w_tmo) begin
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= w_grant_oh;
               end
            end
            ST_RESP: begin
               if (w_rsp_hs) r_rsp_valid <= '0;
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;
   assign aes_start = r_aes_start;
   assign aes_in    = r_aes_in;
   assign aes_key   = r_aes_key;
   assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_aes128_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aes128_arbiter
// Directed bench for aes128_arbiter (N_REQ=4, GAP_CYCLES=2, TIMEOUT=64).
// A small behavioural core answers known plaintext/key pairs after three
// start-high cycles; modes add a stale first-cycle finish or never finish.
// ---------------------------------------------------------------------------
module tb_aes128_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [511:0] req_data;
   logic [511:0] req_key;
   logic [3:0]   rsp_valid;
   logic [3:0]   rsp_ready;
   logic [127:0] rsp_data;
   logic         rsp_err;
   logic         aes_start;
   logic [127:0] aes_in;
   logic [127:0] aes_key;
   logic         aes_finish;
   logic [127:0] aes_out;
   logic         busy;
   logic [2:0]   grant_id;

   aes128_arbiter #(.N_REQ(4), .GAP_CYCLES(2), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_key(req_key),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .aes_start(aes_start), .aes_in(aes_in), .aes_key(aes_key),
      .aes_finish(aes_finish), .aes_out(aes_out),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] KEY     = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
   localparam logic [127:0] GARBAGE = 128'h0123456789abcdef0123456789abcdef;

   logic [127:0] pt [4];
   logic [127:0] ct [4];

   int n_err = 0;
   int n_chk = 0;
   int hi_cnt;
   int core_mode = 0;   // 0 normal, 1 stale first-cycle finish, 2 hung
   int core_cnt  = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] core_model(input logic [127:0] d, input logic [127:0] k);
      core_model = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
      for (int i = 0; i < 4; i++)
         if (d === pt[i] && k === KEY) core_model = ct[i];
   endfunction

   // Behavioural core: finish after three start-high cycles.
   initial begin
      aes_finish = 1'b0;
      aes_out    = '0;
      forever begin
         @(posedge clk);
         #1;
         if (aes_start) core_cnt++;
         else           core_cnt = 0;
         aes_finish = 1'b0;
         aes_out    = '0;
         if (core_cnt > 0) begin
            if (core_mode == 0 && core_cnt >= 3) begin
               aes_finish = 1'b1;
               aes_out    = core_model(aes_in, aes_key);
            end else if (core_mode == 1) begin
               if (core_cnt == 1) begin
                  aes_finish = 1'b1;
                  aes_out    = GARBAGE;
               end else if (core_cnt >= 3) begin
                  aes_finish = 1'b1;
                  aes_out    = core_model(aes_in, aes_key);
               end
            end
         end
      end
   end

   // Poll (bounded) until some req_ready bit is set; comb output checked at +1.
   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      #1;
      while (req_ready == 4'b0 && n < 50) begin
         tick();
         #1;
         n++;
      end
      if (n >= 50) chk({tag, "_ready_timeout"}, 128'(req_ready), 128'hf);
   endtask

   // Poll (bounded) until a response appears, counting start-high cycles.
   task automatic wait_rsp(input string tag);
      int n;
      n = 0;
      hi_cnt = 0;
      while (rsp_valid == 4'b0 && n < 200) begin
         if (aes_start) hi_cnt++;
         tick();
         n++;
      end
      if (n >= 200) chk({tag, "_rsp_timeout"}, 128'(rsp_valid), 128'hf);
   endtask

   initial begin
      pt[0] = 128'h2a179373117e3de9969f402ee2bec16b;
      pt[1] = 128'h518eaf45ac6fb79e9cac031e578a2dae;
      pt[2] = 128'hef520a1a19c1fbe511e45ca3461cc830;
      pt[3] = 128'h10376ce67b412bad179b4fdf45249ff6;
      ct[0] = 128'h97ef6624f3ca9ea860367a0db47bd73a;
      ct[1] = 128'hafbafd965a8985e79d69b90385d5d3f5;
      ct[2] = 128'h880603ede3001b8823ce8e597fcdb143;
      ct[3] = 128'hd45d7204712023823fade8275e780c7b;
      for (int i = 0; i < 4; i++) begin
         req_data[i*128 +: 128] = pt[i];
         req_key[i*128 +: 128]  = KEY;
      end
      req_valid = 4'b0;
      rsp_ready = 4'b1111;
      rst = 1'b1;

      // ---- reset state
      repeat (3) tick();
      chk("rst_aes_start", 128'(aes_start), 128'h0);
      chk("rst_req_ready", 128'(req_ready), 128'h0);
      chk("rst_rsp_valid", 128'(rsp_valid), 128'h0);
      chk("rst_busy",      128'(busy),      128'h0);
      chk("rst_grant_id",  128'(grant_id),  128'h0);
      chk("rst_rsp_err",   128'(rsp_err),   128'h0);
      chk("rst_rsp_data",  rsp_data,        128'h0);
      chk("rst_aes_in",    aes_in,          128'h0);
      rst = 1'b0;
      tick();

      // ---- single job, requester 0, with gap timing
      req_valid = 4'b0001;
      wait_ready("single");
      chk("single_req_ready", 128'(req_ready), 128'h1);
      tick();                               // handshake edge
      req_valid = 4'b0;
      chk("single_gap1_start", 128'(aes_start), 128'h0);
      chk("single_gap1_busy",  128'(busy),      128'h1);
      chk("single_gap1_ready", 128'(req_ready), 128'h0);
      tick();
      chk("single_gap2_start", 128'(aes_start), 128'h0);
      tick();
      chk("single_run_start",  128'(aes_start), 128'h1);
      chk("single_aes_in",     aes_in,          pt[0]);
      chk("single_aes_key",    aes_key,         KEY);
      wait_rsp("single");
      chk("single_rsp_valid",  128'(rsp_valid), 128'h1);
      chk("single_rsp_data",   rsp_data,        ct[0]);
      chk("single_rsp_err",    128'(rsp_err),   128'h0);
      chk("single_hi_cnt",     128'(hi_cnt),    128'd3);
      tick();
      chk("single_done_busy",  128'(busy),      128'h0);
      chk("single_done_valid", 128'(rsp_valid), 128'h0);

      // ---- round robin: all valid after a fresh reset, grants 0,1,2,3,0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_ready("rr");
         chk($sformatf("rr%0d_req_ready", g), 128'(req_ready), 128'(4'b0001 << (g % 4)));
         wait_rsp("rr");
         chk($sformatf("rr%0d_rsp_valid", g), 128'(rsp_valid), 128'(4'b0001 << (g % 4)));
         chk($sformatf("rr%0d_rsp_data", g),  rsp_data,        ct[g % 4]);
         chk($sformatf("rr%0d_grant_id", g),  128'(grant_id),  128'(g % 4));
         if (g == 4) req_valid = 4'b0;
      end
      tick();
      chk("rr_done_busy", 128'(busy), 128'h0);

      // ---- backpressure on requester 1; other rsp_ready bits high
      rsp_ready = 4'b1101;
      req_valid = 4'b0010;
      wait_ready("bp");
      chk("bp_req_ready", 128'(req_ready), 128'h2);
      tick();
      req_valid = 4'b1101;                  // competing requests must wait
      wait_rsp("bp");
      for (int c = 0; c < 10; c++) begin
         #1;
         chk($sformatf("bp%0d_rsp_valid", c), 128'(rsp_valid), 128'h2);
         chk($sformatf("bp%0d_rsp_data", c),  rsp_data,        ct[1]);
         chk($sformatf("bp%0d_req_ready", c), 128'(req_ready), 128'h0);
         chk($sformatf("bp%0d_aes_start", c), 128'(aes_start), 128'h0);
         tick();
      end
      req_valid = 4'b0;
      rsp_ready = 4'b0010;
      tick();
      chk("bp_release_valid", 128'(rsp_valid), 128'h0);
      chk("bp_release_busy",  128'(busy),      128'h0);
      rsp_ready = 4'b1111;

      // ---- stale finish on the first RUN cycle is ignored
      core_mode = 1;
      req_valid = 4'b0001;
      wait_ready("early");
      chk("early_req_ready", 128'(req_ready), 128'h1);
      tick();
      req_valid = 4'b0;
      wait_rsp("early");
      chk("early_rsp_data", rsp_data,     ct[0]);
      chk("early_hi_cnt",   128'(hi_cnt), 128'd3);
      tick();
      core_mode = 2;

      // ---- watchdog timeout on requester 2
      req_valid = 4'b0100;
      wait_ready("tmo");
      chk("tmo_req_ready", 128'(req_ready), 128'h4);
      tick();
      req_valid = 4'b0;
      wait_rsp("tmo");
      chk("tmo_rsp_valid", 128'(rsp_valid), 128'h4);
      chk("tmo_rsp_err",   128'(rsp_err),   128'h1);
      chk("tmo_rsp_data",  rsp_data,        128'h0);
      chk("tmo_hi_cnt",    128'(hi_cnt),    128'd64);
      tick();
      chk("tmo_idle_busy", 128'(busy),      128'h0);

      // ---- reset in the middle of RUN
      req_valid = 4'b1000;
      wait_ready("mid");
      chk("mid_req_ready", 128'(req_ready), 128'h8);
      tick();
      req_valid = 4'b0;
      for (int n = 0; n < 20 && !aes_start; n++) tick();
      chk("mid_in_run", 128'(aes_start), 128'h1);
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_aes_start", 128'(aes_start), 128'h0);
      chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'h0);
      chk("mid_rst_req_ready", 128'(req_ready), 128'h0);
      chk("mid_rst_busy",      128'(busy),      128'h0);
      rst = 1'b0;
      core_mode = 0;
      req_valid = 4'b1111;
      wait_ready("post");
      chk("post_req_ready", 128'(req_ready), 128'h1);
      tick();
      req_valid = 4'b0;
      wait_rsp("post");
      chk("post_rsp_valid", 128'(rsp_valid), 128'h1);
      chk("post_rsp_data",  rsp_data,        ct[0]);
      tick();
      chk("post_done_busy", 128'(busy),      128'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
